// File: rtl/game_result_latch_pkg.sv
// Shared types for the match-outcome latch: the winner code seen by draw_gameover
// and the match FSM states.
package game_pkg;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    OVER_HOLD,
    OVER_WAIT
  } state_t;

  localparam int DEFAULT_HOLD_FRAMES = 120;

endpackage

// File: rtl/game_result_latch.sv
// Two-player match-outcome FSM: gathers collisions per frame, resolves them on
// frame_tick, holds the game-over screen, then accepts a restart.
module game_result_latch
  import game_pkg::*;
#(
  parameter  int HOLD_FRAMES = DEFAULT_HOLD_FRAMES,
  localparam int CNT_W       = $clog2(HOLD_FRAMES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       p1_hit,
  input  logic       p2_hit,
  output logic [1:0] winner_latched,
  output logic       game_running,
  output logic       game_over,
  output logic       restart_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_FRAMES - 1);

  state_t           r_state;
  winner_t          r_winner;
  logic [CNT_W-1:0] r_cnt;
  logic             r_p1_seen, r_p2_seen;
  logic             r_start_pend, r_start_prev;
  logic             r_restart, r_running, r_over;

  state_t           w_state_nxt;
  winner_t          w_winner_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_p1_nxt, w_p2_nxt;
  logic             w_pend_nxt, w_restart_nxt;
  logic             w_start_edge, w_pend_eff, w_p1_eff, w_p2_eff;

  assign w_start_edge = start_btn & ~r_start_prev;
  assign w_pend_eff   = r_start_pend | w_start_edge;
  // A hit on the tick cycle itself still belongs to the frame being closed.
  assign w_p1_eff     = r_p1_seen | p1_hit;
  assign w_p2_eff     = r_p2_seen | p2_hit;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_winner_nxt  = r_winner;
    w_cnt_nxt     = r_cnt;
    w_p1_nxt      = 1'b0;
    w_p2_nxt      = 1'b0;
    w_pend_nxt    = r_start_pend;
    w_restart_nxt = 1'b0;

    case (r_state)
      IDLE, OVER_WAIT: begin
        w_pend_nxt = w_pend_eff;
        if (frame_tick && w_pend_eff) begin
          w_state_nxt   = RUNNING;
          w_winner_nxt  = WIN_NONE;
          w_pend_nxt    = 1'b0;
          w_restart_nxt = 1'b1;
        end
      end
      RUNNING: begin
        w_p1_nxt = w_p1_eff;
        w_p2_nxt = w_p2_eff;
        if (frame_tick) begin
          w_p1_nxt = 1'b0;
          w_p2_nxt = 1'b0;
          if (w_p1_eff || w_p2_eff) begin
            // The player who crashed loses, so a lone p1 hit means P2 wins.
            if (w_p1_eff && w_p2_eff) w_winner_nxt = WIN_DRAW;
            else if (w_p1_eff)        w_winner_nxt = WIN_P2;
            else                      w_winner_nxt = WIN_P1;
            w_state_nxt = OVER_HOLD;
            w_cnt_nxt   = '0;
          end
        end
      end
      OVER_HOLD: begin
        if (frame_tick) begin
          if (r_cnt == CNT_LAST) w_state_nxt = OVER_WAIT;
          else                   w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_winner     <= WIN_NONE;
      r_cnt        <= '0;
      r_p1_seen    <= 1'b0;
      r_p2_seen    <= 1'b0;
      r_start_pend <= 1'b0;
      r_start_prev <= 1'b1;
      r_restart    <= 1'b0;
      r_running    <= 1'b0;
      r_over       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_winner     <= w_winner_nxt;
      r_cnt        <= w_cnt_nxt;
      r_p1_seen    <= w_p1_nxt;
      r_p2_seen    <= w_p2_nxt;
      r_start_pend <= w_pend_nxt;
      r_start_prev <= start_btn;
      r_restart    <= w_restart_nxt;
      r_running    <= (w_state_nxt == RUNNING);
      r_over       <= (w_state_nxt == OVER_HOLD) || (w_state_nxt == OVER_WAIT);
    end
  end

  assign winner_latched = r_winner;
  assign game_running   = r_running;
  assign game_over      = r_over;
  assign restart_pulse  = r_restart;

endmodule

// File: tb/tb_game_result_latch.sv
// Self-checking bench for game_result_latch: directed match scenarios with literal
// expectations, then randomized play compared against a frame-level outcome model.
module tb_game_result_latch;

  localparam int HOLD = 3;
  localparam int TICK_PERIOD = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       p1_hit = 1'b0;
  logic       p2_hit = 1'b0;
  logic [1:0] winner_latched;
  logic       game_running;
  logic       game_over;
  logic       restart_pulse;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  game_result_latch #(.HOLD_FRAMES(HOLD)) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .start_btn     (start_btn),
    .p1_hit        (p1_hit),
    .p2_hit        (p2_hit),
    .winner_latched(winner_latched),
    .game_running  (game_running),
    .game_over     (game_over),
    .restart_pulse (restart_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, got, exp, cyc, $time);
    end
  endtask

  // Behavioural model: the match is "waiting", "playing", or "showing result"
  // with a number of frames still to show before restart is allowed.
  bit model_valid = 0;
  bit m_playing, m_showing, m_awaiting_start, m_restart;
  int m_winner, m_frames_left;
  bit m_btn_before, m_want_start, m_p1_crashed, m_p2_crashed;

  always @(posedge clk) begin
    bit pressed;
    if (rst) begin
      model_valid      = 1;
      m_playing        = 0;
      m_showing        = 0;
      m_awaiting_start = 1;
      m_restart        = 0;
      m_winner         = 0;
      m_frames_left    = 0;
      m_btn_before     = 1;
      m_want_start     = 0;
      m_p1_crashed     = 0;
      m_p2_crashed     = 0;
    end else begin
      pressed      = start_btn && !m_btn_before;
      m_btn_before = start_btn;
      m_restart    = 0;
      if (m_awaiting_start) begin
        m_want_start = m_want_start || pressed;
        if (frame_tick && m_want_start) begin
          m_awaiting_start = 0;
          m_showing        = 0;
          m_playing        = 1;
          m_restart        = 1;
          m_winner         = 0;
          m_want_start     = 0;
        end
      end else if (m_playing) begin
        m_p1_crashed = m_p1_crashed || p1_hit;
        m_p2_crashed = m_p2_crashed || p2_hit;
        if (frame_tick) begin
          if (m_p1_crashed || m_p2_crashed) begin
            m_winner      = (m_p1_crashed ? 2 : 0) + (m_p2_crashed ? 1 : 0);
            m_playing     = 0;
            m_showing     = 1;
            m_frames_left = HOLD;
          end
          m_p1_crashed = 0;
          m_p2_crashed = 0;
        end
      end else if (frame_tick) begin
        m_frames_left--;
        if (m_frames_left == 0) m_awaiting_start = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("winner", winner_latched, m_winner);
      check("running", game_running, m_playing);
      check("over", game_over, m_showing);
      check("restart", restart_pulse, m_restart);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    cyc++;
    frame_tick = (cyc % TICK_PERIOD == 0);
    p1_hit = 1'b0;
    p2_hit = 1'b0;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    cyc = 0;
    frame_tick = 1'b0;
  endtask

  task automatic expect_outs(input string tag, input int w, input int run, input int over, input int rp);
    check({tag, ".winner"}, winner_latched, w);
    check({tag, ".running"}, game_running, run);
    check({tag, ".over"}, game_over, over);
    check({tag, ".restart"}, restart_pulse, rp);
  endtask

  initial begin
    // Button held through reset must not start a game; hits in IDLE ignored.
    start_btn = 1'b1;
    do_reset();
    expect_outs("reset", 0, 0, 0, 0);
    run_to(50);  p1_hit = 1'b1;
    run_to(101); expect_outs("held_start", 0, 0, 0, 0);

    // Main match sequence.
    start_btn = 1'b0;
    do_reset();
    run_to(20);  start_btn = 1'b1;
    run_to(100); expect_outs("pre_tick", 0, 0, 0, 0);
    run_to(101); expect_outs("start", 0, 1, 0, 1);
    run_to(102); expect_outs("start_next", 0, 1, 0, 0);
    run_to(250); p2_hit = 1'b1;
    run_to(299); expect_outs("p2_mid", 0, 1, 0, 0);
    run_to(301); expect_outs("p2_tick", 1, 0, 1, 0);
    run_to(303); start_btn = 1'b0;
    run_to(305); start_btn = 1'b1;
    run_to(601); expect_outs("hold_done", 1, 0, 1, 0);
    run_to(701); expect_outs("no_pend", 1, 0, 1, 0);
    run_to(720); p1_hit = 1'b1;
    run_to(730); start_btn = 1'b0;
    run_to(731); expect_outs("wait_hit", 1, 0, 1, 0);
    run_to(740); start_btn = 1'b1;
    run_to(801); expect_outs("restart", 0, 1, 0, 1);
    run_to(810); p1_hit = 1'b1;
    run_to(870); p2_hit = 1'b1;
    run_to(901); expect_outs("draw", 3, 0, 1, 0);
    run_to(1205); start_btn = 1'b0;
    run_to(1210); start_btn = 1'b1;
    run_to(1301); expect_outs("restart2", 0, 1, 0, 1);
    run_to(1400); p1_hit = 1'b1;
    run_to(1401); expect_outs("p1_on_tick", 2, 0, 1, 0);
    run_to(1450); rst = 1'b1;
    step();       rst = 1'b0;
    expect_outs("mid_reset", 0, 0, 0, 0);
    run_to(1455); start_btn = 1'b0;
    run_to(1460); start_btn = 1'b1;
    run_to(1501); expect_outs("after_reset", 0, 1, 0, 1);

    // Randomized play against the model.
    for (int i = 0; i < 20000; i++) begin
      step();
      if ($urandom_range(0, 39) == 0) start_btn = ~start_btn;
      p1_hit = ($urandom_range(0, 249) == 0);
      p2_hit = ($urandom_range(0, 249) == 0);
      rst    = ($urandom_range(0, 4999) == 0);
    end
    step();
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
